// File: rtl/ex3_serial_rx_pkg.sv
// Shared definitions for the Excess-3 serial receiver: FSM encoding and legal code range.
package ex3_serial_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   localparam logic [3:0] EX3_MIN = 4'd3;
   localparam logic [3:0] EX3_MAX = 4'd12;

   function automatic logic ex3_illegal(input logic [3:0] code);
      return (code < EX3_MIN) || (code > EX3_MAX);
   endfunction

endpackage

// File: rtl/ex3_check.sv
// Combinational legality test for one Excess-3 digit: err=1 when code is outside 3..12.
module ex3_check
   import ex3_serial_rx_pkg::*;
(
   input  logic [3:0] code,
   output logic       err
);

   assign err = ex3_illegal(code);

endmodule

// File: rtl/ex3_serial_rx.sv
// Bit-serial Excess-3 frame receiver: assembles DIGITS digits LSB-first, flags
// illegal digits and presents the frame on a valid/ready handshake.
module ex3_serial_rx
   import ex3_serial_rx_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  bit_in,
   input  logic                  bit_valid,
   input  logic                  sof,
   output logic                  in_ready,
   output logic [4*DIGITS-1:0]   ex3_out,
   output logic [DIGITS-1:0]     digit_err,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  overrun,
   output logic                  resync
);

   localparam int NBITS = 4 * DIGITS;
   localparam int CW    = $clog2(NBITS);
   localparam logic [CW-1:0] LAST_IDX = CW'(NBITS - 1);

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     idx;
   logic              take;
   logic              is_last;
   logic [NBITS-1:0]  shift_next;
   logic [DIGITS-1:0] lane_err;
   logic [DIGITS-1:0] err_next;

   // In IDLE only an sof bit starts a frame; plain bits there are ignored.
   assign take    = bit_valid && in_ready && (sof || (state == ST_SHIFT));
   assign idx     = sof ? '0 : cnt;
   assign is_last = (idx == LAST_IDX);

   always_comb begin
      shift_next      = sof ? '0 : ex3_out;
      shift_next[idx] = bit_in;
   end

   // Each digit's flag is captured from the lane as it will look once its 4th bit lands.
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lane
         ex3_check u_check (
            .code (shift_next[4*gi +: 4]),
            .err  (lane_err[gi])
         );
         assign err_next[gi] = (idx == CW'(4*gi + 3)) ? lane_err[gi]
                             : (sof ? 1'b0 : digit_err[gi]);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         ex3_out   <= '0;
         digit_err <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
         resync    <= 1'b0;
      end else begin
         overrun <= bit_valid && !in_ready;
         resync  <= 1'b0;
         case (state)
            ST_IDLE, ST_SHIFT: begin
               if (take) begin
                  ex3_out   <= shift_next;
                  digit_err <= err_next;
                  resync    <= sof && (state == ST_SHIFT);
                  if (is_last) begin
                     state     <= ST_HOLD;
                     cnt       <= '0;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end else begin
                     state <= ST_SHIFT;
                     cnt   <= idx + 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  state     <= ST_IDLE;
                  cnt       <= '0;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               cnt       <= '0;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ex3_serial_rx.sv
// Directed bench for ex3_serial_rx (DIGITS=4): frames are scoreboarded when sent
// and compared when the receiver presents them.
module tb_ex3_serial_rx;

   localparam int DIGITS = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        bit_in = 1'b0;
   logic        bit_valid = 1'b0;
   logic        sof = 1'b0;
   logic        out_ready = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic        overrun;
   logic        resync;
   logic [15:0] ex3_out;
   logic [3:0]  digit_err;

   int checks = 0;
   int errors = 0;
   int resync_cnt = 0;
   int overrun_cnt = 0;

   typedef struct packed {
      logic [15:0] data;
      logic [3:0]  err;
   } frame_t;

   frame_t exp_q[$];

   always #5 clk = ~clk;

   ex3_serial_rx #(.DIGITS(DIGITS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bit_in    (bit_in),
      .bit_valid (bit_valid),
      .sof       (sof),
      .in_ready  (in_ready),
      .ex3_out   (ex3_out),
      .digit_err (digit_err),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overrun   (overrun),
      .resync    (resync)
   );

   always @(negedge clk) begin
      if (resync)  resync_cnt++;
      if (overrun) overrun_cnt++;
   end

   function automatic logic [3:0] model_err(input logic [15:0] d);
      logic [3:0] e;
      logic [3:0] dig;
      for (int k = 0; k < 4; k++) begin
         dig  = d[4*k +: 4];
         e[k] = (dig < 4'd3) || (dig > 4'd12);
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b, input logic s);
      bit_in    = b;
      sof       = s;
      bit_valid = 1'b1;
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
      sof       = 1'b0;
      bit_in    = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] d, input int gap_at);
      exp_q.push_back({d, model_err(d)});
      for (int i = 0; i < 16; i++) begin
         if (i == gap_at) begin
            @(posedge clk);
            #1;
         end
         if (i == 15) chk("pre_last_valid", 32'(out_valid), 32'd0);
         send_bit(d[i], i == 0);
      end
      chk("latency_valid", 32'(out_valid), 32'd1);
   endtask

   task automatic recv_frame(input string tag);
      frame_t f;
      int n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
         f = exp_q.pop_front();
         chk({tag, "_data"}, 32'(ex3_out), 32'(f.data));
         chk({tag, "_err"}, 32'(digit_err), 32'(f.err));
      end
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_hs_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int r0;
      int o0;

      // 1: reset mid-stream
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
      rst_n = 1'b0;
      #1;
      chk("rst_data", 32'(ex3_out), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_err", 32'(digit_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_rel_in_ready", 32'(in_ready), 32'd1);
      chk("rst_rel_valid", 32'(out_valid), 32'd0);

      // non-sof bit in IDLE is ignored
      send_bit(1'b1, 1'b0);
      chk("idle_ignore_data", 32'(ex3_out), 32'd0);

      // 2: legal frame
      send_frame(16'hC943, 99);
      recv_frame("f_c943");
      handshake("f_c943");
      chk("idle_keeps_frame", 32'(ex3_out), 32'h0000C943);

      // 3: illegal digit 2, with an idle gap mid-frame
      send_frame(16'h3F53, 6);
      recv_frame("f_3f53");
      chk("f_3f53_err_const", 32'(digit_err), 32'h4);
      handshake("f_3f53");

      // 4: backpressure with overrun
      send_frame(16'h8654, 99);
      recv_frame("f_bp");
      o0 = overrun_cnt;
      for (int i = 0; i < 10; i++) begin
         bit_valid = 1'b1;
         bit_in    = i[0];
         @(posedge clk);
         #1;
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_data", 32'(ex3_out), 32'h00008654);
         chk("bp_err", 32'(digit_err), 32'd0);
      end
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      @(posedge clk);
      #1;
      chk("bp_overrun_count", 32'(overrun_cnt - o0), 32'd10);
      chk("bp_overrun_idle", 32'(overrun), 32'd0);
      handshake("f_bp");

      // 5: resync after 7 bits
      r0 = resync_cnt;
      for (int i = 0; i < 7; i++) send_bit(1'b1, i == 0);
      chk("pre_resync_count", 32'(resync_cnt - r0), 32'd0);
      send_frame(16'h7A65, 99);
      recv_frame("f_resync");
      handshake("f_resync");
      chk("resync_count", 32'(resync_cnt - r0), 32'd1);

      // 6: reset after 9 bits, then clean frame
      for (int i = 0; i < 9; i++) send_bit(1'b0, i == 0);
      rst_n = 1'b0;
      #1;
      chk("rst2_data", 32'(ex3_out), 32'd0);
      chk("rst2_err", 32'(digit_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_frame(16'h5BC6, 3);
      recv_frame("f_5bc6");
      handshake("f_5bc6");

      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
